// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// md-class decode helpers used by the unit and by the stall controller.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } md_state_e;

  // True for any op the unit accepts; 6 and 7 are reserved.
  function automatic logic md_is_class(input logic [2:0] op);
    return op <= MD_MTLO;
  endfunction

  // True for the multi-cycle mul/div ops.
  function automatic logic md_is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage request/response bundle for md_unit: the pipeline is the master, the
// unit is the slave.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_arith.sv
// Combinational signed/unsigned multiply and divide. Division is done on
// magnitudes so INT_MIN / -1 naturally yields {hi=0, lo=INT_MIN}.
module md_arith
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]         op3;
  logic               is_signed;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign op3       = {1'b0, op};
  assign is_signed = (op3 == MD_MULT) || (op3 == MD_DIV);
  assign is_div    = (op3 == MD_DIV) || (op3 == MD_DIVU);

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];

  // Low 2*WIDTH bits of the extended product equal the signed product.
  assign a_ext = {{WIDTH{a_neg}}, a};
  assign b_ext = {{WIDTH{b_neg}}, b};
  assign prod  = a_ext * b_ext;

  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div_zero = is_div && (b == '0);
  assign divisor  = div_zero ? One : b_mag;
  assign quo_mag  = a_mag / divisor;
  assign rem_mag  = a_mag % divisor;
  assign quo      = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
  assign rem      = a_neg ? -rem_mag : rem_mag;

  assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div ? quo : prod[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// Optional flush input `cancel` is enabled by defining MD_UNIT_CANCEL_EN.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic     clk,
  input  logic     rst,
`ifdef MD_UNIT_CANCEL_EN
  input  logic     cancel,
`endif
  md_unit_if.slave bus
);

  localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_LAT);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_LAT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  md_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;
  logic             kill;
  logic             is_div_op;

`ifdef MD_UNIT_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  assign is_div_op = (bus.op == MD_DIV) || (bus.op == MD_DIVU);

  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op       (bus.op[1:0]),
    .a        (bus.a),
    .b        (bus.b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && !kill && md_is_class(bus.op)) begin
            if (md_is_arith(bus.op)) begin
              // Divide by zero re-commits the current HI/LO so they appear unchanged.
              pend_hi_q <= div_zero ? hi_q : res_hi;
              pend_lo_q <= div_zero ? lo_q : res_lo;
              cnt_q     <= is_div_op ? DivCnt : MultCnt;
              busy_q    <= 1'b1;
              state_q   <= StRun;
            end else if (bus.op == MD_MTHI) begin
              hi_q <= bus.a;
            end else begin
              lo_q <= bus.a;
            end
          end
        end
        StRun: begin
          if (kill) begin
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else if (cnt_q == CntOne) begin
            hi_q    <= pend_hi_q;
            lo_q    <= pend_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit against a 64-bit arithmetic
// reference model; cancel checks run when MD_UNIT_CANCEL_EN is defined.
module tb_md_unit;

  localparam int unsigned MultLat = 5;
  localparam int unsigned DivLat  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef MD_UNIT_CANCEL_EN
  logic cancel = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_unit_if #(.WIDTH(32)) bus_if ();

  md_unit #(
    .WIDTH    (32),
    .MULT_LAT (MultLat),
    .DIV_LAT  (DivLat)
  ) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef MD_UNIT_CANCEL_EN
    .cancel (cancel),
`endif
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted op on {hi, lo}.
  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        inout logic [31:0] hi, inout logic [31:0] lo);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic        [63:0] up;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    case (op)
      3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
      3'd3: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [31:0] eh, el;
    int unsigned lat, cycles;
    eh = hi_m;
    el = lo_m;
    md_ref(op, a, b, eh, el);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a     = a;
    bus_if.b     = b;
    tick();
    bus_if.start = 1'b0;
    if (op <= 3'd3) begin
      lat = (op >= 3'd2) ? DivLat : MultLat;
      cycles = 0;
      while (bus_if.busy === 1'b1 && cycles < 40) begin
        check("hold_hi", bus_if.hi, hi_m);
        check("hold_lo", bus_if.lo, lo_m);
        // A second op raised mid-run must be ignored.
        if (poke && cycles == 1) begin
          bus_if.start = 1'b1;
          bus_if.op    = 3'd0;
          bus_if.a     = $urandom;
          bus_if.b     = $urandom;
        end else begin
          bus_if.start = 1'b0;
        end
        tick();
        cycles++;
      end
      bus_if.start = 1'b0;
      check("busy_cycles", cycles, lat);
    end else begin
      check("busy_single", {31'd0, bus_if.busy}, 32'd0);
    end
    check("hi", bus_if.hi, eh);
    check("lo", bus_if.lo, el);
    hi_m = eh;
    lo_m = el;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus_if.start = 1'b0;
    bus_if.op    = '0;
    bus_if.a     = '0;
    bus_if.b     = '0;

    #3;
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("rst_hi", bus_if.hi, 32'd0);
    check("rst_lo", bus_if.lo, 32'd0);
    #10 rst = 1'b1;
    tick();

    // Reset in the middle of a MULT discards it.
    bus_if.start = 1'b1;
    bus_if.op    = 3'd0;
    bus_if.a     = 32'd3;
    bus_if.b     = 32'd4;
    tick();
    bus_if.start = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("midrun_rst_hi", bus_if.hi, 32'd0);
    check("midrun_rst_lo", bus_if.lo, 32'd0);
    #1 rst = 1'b1;
    repeat (8) tick();
    check("post_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    check("post_rst_hi", bus_if.hi, 32'd0);
    check("post_rst_lo", bus_if.lo, 32'd0);

    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(3'd3, 32'd7, 32'd2, 1'b0);
    issue(3'd4, 32'd5, 32'd0, 1'b0);
    issue(3'd5, 32'd6, 32'd0, 1'b0);
    issue(3'd2, 32'd9, 32'd0, 1'b0);
    issue(3'd3, 32'd9, 32'd0, 1'b0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
    issue(3'd0, 32'd1000, 32'd77, 1'b1);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    issue(3'd7, 32'hCAFE_F00D, 32'd1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'd1;
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, bit'($urandom_range(0, 1)));
    end

`ifdef MD_UNIT_CANCEL_EN
    issue(3'd4, 32'h0000_AAAA, 32'd0, 1'b0);
    issue(3'd5, 32'h0000_BBBB, 32'd0, 1'b0);
    bus_if.start = 1'b1;
    bus_if.op    = 3'd0;
    bus_if.a     = 32'd5;
    bus_if.b     = 32'd6;
    tick();
    bus_if.start = 1'b0;
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, bus_if.busy}, 32'd0);
    check("cancel_hi", bus_if.hi, hi_m);
    check("cancel_lo", bus_if.lo, lo_m);
    repeat (8) tick();
    check("cancel_late_hi", bus_if.hi, hi_m);
    check("cancel_late_lo", bus_if.lo, lo_m);
    bus_if.start = 1'b1;
    bus_if.op    = 3'd4;
    bus_if.a     = 32'h0000_0001;
    cancel       = 1'b1;
    tick();
    bus_if.start = 1'b0;
    cancel       = 1'b0;
    check("cancel_idle_hi", bus_if.hi, hi_m);
    check("cancel_idle_busy", {31'd0, bus_if.busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
